axis_layer_deserializer: RTL and testbench
==========================================

# axis_layer_deserializer

Receiving end of the inter-layer AXI4-Stream link: accepts a stream of 32-bit activation words from the previous layer's stream output and reassembles them into one parallel frame of N_WORDS registers. It presents the frame to the next layer's neuron array with a one-cycle start pulse. It holds the frame stable and back-pressures the stream until the consumer acknowledges. It sits between the stream interconnect and the next layer's per-neuron inputs.

## Interface
- N_WORDS, 18, words per frame (one per neuron of the previous layer); ≥2
- DATA_W, 32, word width
- USE_TLAST, 0, 1 = check s_tlast against frame boundary; 0 = ignore s_tlast
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- s_tdata  in  DATA_W  stream word
- s_tvalid  in  1  stream word valid
- s_tlast  in  1  end-of-frame marker (used only when USE_TLAST=1)
- s_tready  out  1  registered; 1 only in FILL
- frame_data  out  N_WORDS*DATA_W  word i at bits [i*DATA_W +: DATA_W]; word 0 is the first beat
- frame_valid  out  1  level; frame_data is complete and stable
- frame_start  out  1  one-cycle pulse on the cycle frame_valid rises
- frame_ack  in  1  consumer has latched the frame; honoured only while frame_valid=1
- err_early_last  out  1  one-cycle pulse: s_tlast arrived before beat N_WORDS-1 (USE_TLAST=1)
- err_missing_last  out  1  one-cycle pulse: beat N_WORDS-1 arrived without s_tlast (USE_TLAST=1)
- frame_count  out  16  completed frames, wraps 0xFFFF→0

## Operation
- States: RST_WAIT, FILL, HOLD. Reset enters RST_WAIT. The first clock after resetn deasserts moves to FILL with s_tready←1.
- Beat accepted ⇔ s_tvalid & s_tready on a rising edge. Word stored at index idx; idx increments (width clog2(N_WORDS)).
- Accept with idx==N_WORDS-1 → state HOLD, s_tready←0, frame_valid←1, frame_start←1 for one cycle, idx←0, frame_count+1.
- USE_TLAST=1 and s_tlast=1 on an accepted beat with idx<N_WORDS-1 → partial frame discarded, idx←0, err_early_last pulse, stay in FILL. The stored words need not be cleared.
- USE_TLAST=1, last beat accepted with s_tlast=0 → frame still completes normally; err_missing_last pulses in the same cycle as frame_start.
- HOLD: frame_data frozen. s_tvalid/s_tdata ignored. frame_ack=1 → FILL, s_tready←1, frame_valid←0.
- frame_ack during FILL or RST_WAIT: ignored, no effect.
- resetn low at any time (mid-frame or in HOLD): partial or held frame abandoned. The next frame starts at word 0.
- Reset values: s_tready=0, frame_valid=0, frame_start=0, err_early_last=0, err_missing_last=0, frame_count=0, frame_data=0, idx=0.

## Timing
- Last beat accepted at edge T → frame_valid=1 and frame_start=1 in the cycle after T. frame_start is 0 after edge T+1.
- frame_ack sampled 1 at edge A → frame_valid=0 and s_tready=1 after A. The next beat can be accepted at edge A+1.
- Steady-state throughput: N_WORDS beats per frame plus a minimum of 1 cycle in HOLD (ack on the first HOLD cycle) → N_WORDS+1 cycles/frame.
- s_tready never depends combinationally on s_tvalid or frame_ack. It changes only on a clock edge.
- A producer holding s_tvalid high with stable s_tdata across back-pressure must lose no beats and duplicate none.

## Structure
- Shared package: state encoding (RST_WAIT/FILL/HOLD), default DATA_W=32 and N_WORDS=18 layer constants, frame_count width. These are shared with the stream-output connector and the layer top.
- One sub-module, axis_frame_store: N_WORDS×DATA_W register file with write-enable plus index, and flat read-out. The FSM, index counter, and error logic stay in the top.

## Test plan
- Reset, then 18 beats 0x100..0x111 with s_tvalid held high → s_tready low after beat 18; frame_start single pulse; frame_data word 0=0x100, word 17=0x111; frame_count=1.
- Random s_tvalid gaps (≈50%) over 3 frames, ack delayed 0/1/5 cycles → every word matches in order; no beat accepted while frame_valid=1; frame_count=3.
- USE_TLAST=1, s_tlast on beat 5 → err_early_last pulses once; no frame_start; the next 18 beats form a correct frame.
- USE_TLAST=1, 18 beats without s_tlast → frame_start and err_missing_last in the same cycle; data correct.
- resetn pulsed low after beat 9 → all outputs at reset values; after release, 18 new beats form a complete frame starting at word 0.
- frame_ack asserted during FILL → no state change, no frame_valid; frame_count preset near 0xFFFF wraps to 0 after the next frame.

Source files
------------

// File: rtl/axis_layer_deserializer_pkg.sv
// Layer-link constants and deserializer state encoding, shared with the
// stream-output connector and the layer top.
package axis_layer_deserializer_pkg;

   localparam int LAYER_DATA_W  = 32;
   localparam int LAYER_N_WORDS = 18;
   localparam int FRAME_CNT_W   = 16;

   typedef enum logic [1:0] {
      RST_WAIT = 2'd0,
      FILL     = 2'd1,
      HOLD     = 2'd2
   } deser_state_e;

endpackage

// File: rtl/axis_layer_deserializer_frame_store.sv
// N_WORDS x DATA_W frame register file: indexed single-word write,
// whole frame presented flat with word 0 in the low bits.
module axis_frame_store
   import axis_layer_deserializer_pkg::*;
#(
   parameter int N_WORDS = LAYER_N_WORDS,
   parameter int DATA_W  = LAYER_DATA_W,
   parameter int IDX_W   = $clog2(N_WORDS)
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      wr_en,
   input  logic [IDX_W-1:0]          wr_idx,
   input  logic [DATA_W-1:0]         wr_data,
   output logic [N_WORDS*DATA_W-1:0] rd_flat
);

   logic [N_WORDS*DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_q <= '0;
      end else begin
         for (int i = 0; i < N_WORDS; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
               data_q[i*DATA_W +: DATA_W] <= wr_data;
            end
         end
      end
   end

   assign rd_flat = data_q;

endmodule

// File: rtl/axis_layer_deserializer.sv
// Inter-layer AXI4-Stream receiver: collects N_WORDS beats into a parallel
// frame, holds it with back-pressure until the next layer acknowledges.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RST_WAIT | first cycle out of reset, stream not yet accepted
//   FILL     | s_tready=1, beats written at idx
//   HOLD     | frame complete and frozen, waiting for frame_ack
module axis_layer_deserializer
   import axis_layer_deserializer_pkg::*;
#(
   parameter int N_WORDS   = LAYER_N_WORDS,
   parameter int DATA_W    = LAYER_DATA_W,
   parameter int USE_TLAST = 0
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [DATA_W-1:0]         s_tdata,
   input  logic                      s_tvalid,
   input  logic                      s_tlast,
   output logic                      s_tready,
   output logic [N_WORDS*DATA_W-1:0] frame_data,
   output logic                      frame_valid,
   output logic                      frame_start,
   input  logic                      frame_ack,
   output logic                      err_early_last,
   output logic                      err_missing_last,
   output logic [FRAME_CNT_W-1:0]    frame_count
);

   localparam int               IDX_W    = $clog2(N_WORDS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);
   localparam bit               TLAST_ON = (USE_TLAST != 0);

   deser_state_e           state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, cnt_d;
   logic                   tready_q, tready_d;
   logic                   fvalid_q, fvalid_d;
   logic                   start_q, start_d;
   logic                   early_q, early_d;
   logic                   missing_q, missing_d;
   logic                   accept;
   logic                   wr_en;

   assign accept = s_tvalid & tready_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= RST_WAIT;
         idx_q       <= '0;
         frame_cnt_q <= '0;
         tready_q    <= 1'b0;
         fvalid_q    <= 1'b0;
         start_q     <= 1'b0;
         early_q     <= 1'b0;
         missing_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         frame_cnt_q <= cnt_d;
         tready_q    <= tready_d;
         fvalid_q    <= fvalid_d;
         start_q     <= start_d;
         early_q     <= early_d;
         missing_q   <= missing_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = frame_cnt_q;
      start_d   = 1'b0;
      early_d   = 1'b0;
      missing_d = 1'b0;
      wr_en     = 1'b0;
      case (state_q)
         RST_WAIT: state_d = FILL;
         FILL: begin
            if (accept) begin
               wr_en = 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d   = HOLD;
                  idx_d     = '0;
                  cnt_d     = frame_cnt_q + 1'b1;
                  start_d   = 1'b1;
                  missing_d = TLAST_ON && !s_tlast;
               end else if (TLAST_ON && s_tlast) begin
                  // early end: drop the partial frame, old words may linger
                  idx_d   = '0;
                  early_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (frame_ack) state_d = FILL;
         end
         default: state_d = RST_WAIT;
      endcase
      tready_d = (state_d == FILL);
      fvalid_d = (state_d == HOLD);
   end

   axis_frame_store #(
      .N_WORDS (N_WORDS),
      .DATA_W  (DATA_W),
      .IDX_W   (IDX_W)
   ) u_store (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (wr_en),
      .wr_idx  (idx_q),
      .wr_data (s_tdata),
      .rd_flat (frame_data)
   );

   assign s_tready         = tready_q;
   assign frame_valid      = fvalid_q;
   assign frame_start      = start_q;
   assign err_early_last   = early_q;
   assign err_missing_last = missing_q;
   assign frame_count      = frame_cnt_q;

endmodule

// File: tb/tb_axis_layer_deserializer.sv
// Directed bench for axis_layer_deserializer: one instance ignoring s_tlast,
// one checking it, driven one at a time through a frame-scenario table.
module tb_axis_layer_deserializer;

   localparam int N = 18;
   localparam int W = 32;

   typedef struct {
      int          sel;
      logic [31:0] base;
      bit          gaps;
      int          ack_dly;
      int          tlast_at;
      bit          exp_start;
      bit          exp_early;
      bit          exp_missing;
      logic [15:0] exp_cnt;
   } vec_t;

   logic         clk;
   logic         resetn;
   logic [W-1:0] s_tdata;
   logic         s_tlast;
   logic         frame_ack;
   logic         v0, v1;
   logic         r0, r1, fv0, fv1, fs0, fs1, ee0, ee1, em0, em1;
   logic [N*W-1:0] fd0, fd1;
   logic [15:0]  cnt0, cnt1;

   int   sel;
   logic obs_rdy, obs_fv, obs_fs, obs_early, obs_miss;
   logic [N*W-1:0] obs_fd;
   logic [15:0] obs_cnt;

   int checks = 0;
   int errors = 0;
   int bad_acc = 0;
   vec_t vecs[8];

   axis_layer_deserializer #(.N_WORDS(N), .DATA_W(W), .USE_TLAST(0)) u0 (
      .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(v0), .s_tlast(s_tlast),
      .s_tready(r0), .frame_data(fd0), .frame_valid(fv0), .frame_start(fs0),
      .frame_ack(frame_ack), .err_early_last(ee0), .err_missing_last(em0), .frame_count(cnt0));

   axis_layer_deserializer #(.N_WORDS(N), .DATA_W(W), .USE_TLAST(1)) u1 (
      .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(v1), .s_tlast(s_tlast),
      .s_tready(r1), .frame_data(fd1), .frame_valid(fv1), .frame_start(fs1),
      .frame_ack(frame_ack), .err_early_last(ee1), .err_missing_last(em1), .frame_count(cnt1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      obs_rdy   = (sel == 1) ? r1  : r0;
      obs_fv    = (sel == 1) ? fv1 : fv0;
      obs_fs    = (sel == 1) ? fs1 : fs0;
      obs_early = (sel == 1) ? ee1 : ee0;
      obs_miss  = (sel == 1) ? em1 : em0;
      obs_fd    = (sel == 1) ? fd1 : fd0;
      obs_cnt   = (sel == 1) ? cnt1 : cnt0;
   end

   always @(posedge clk) begin
      if ((v0 && r0 && fv0) || (v1 && r1 && fv1)) bad_acc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_valid(input logic b);
      v0 = b && (sel == 0);
      v1 = b && (sel == 1);
   endtask

   // Drives one beat from a negedge and returns at the negedge after acceptance.
   task automatic send_beat(input logic [W-1:0] d, input logic last);
      int n;
      n = 0;
      s_tdata = d;
      s_tlast = last;
      set_valid(1'b1);
      while (!obs_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!obs_rdy) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: s_tready got 0 expected 1 for data %0h", d);
      end
      @(negedge clk);
   endtask

   task automatic check_words(input logic [31:0] base, input string tag);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s_word%0d", tag, i), obs_fd[i*W +: W], base + 32'(i));
      end
   endtask

   task automatic run_vec(input vec_t v);
      int nb;
      sel = v.sel;
      nb = v.exp_early ? v.tlast_at + 1 : N;
      for (int i = 0; i < nb; i++) begin
         if (v.gaps && ($urandom_range(0, 1) == 1)) begin
            set_valid(1'b0);
            @(negedge clk);
         end
         send_beat(v.base + 32'(i), i == v.tlast_at);
      end
      set_valid(1'b0);
      s_tlast = 1'b0;
      check("frame_start", obs_fs, v.exp_start);
      check("frame_valid", obs_fv, v.exp_start);
      check("err_early_last", obs_early, v.exp_early);
      check("err_missing_last", obs_miss, v.exp_missing);
      check("s_tready", obs_rdy, !v.exp_start);
      check("frame_count", obs_cnt, v.exp_cnt);
      if (v.exp_start) check_words(v.base, "frame");
      for (int k = 0; k < v.ack_dly; k++) begin
         s_tdata = 32'hDEAD_0000 | 32'(k);
         set_valid(1'b1);
         @(negedge clk);
      end
      set_valid(1'b0);
      if (v.ack_dly > 0) begin
         check("hold_valid", obs_fv, 1'b1);
         check("hold_ready", obs_rdy, 1'b0);
         check_words(v.base, "held");
      end
      if (v.exp_start) frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      check("start_pulse_end", obs_fs, 1'b0);
      check("early_pulse_end", obs_early, 1'b0);
      check("missing_pulse_end", obs_miss, 1'b0);
      check("post_ack_valid", obs_fv, 1'b0);
      check("post_ack_ready", obs_rdy, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t rv;
      //          sel base         gaps ack tlast start early miss cnt
      vecs[0] = '{0, 32'h0000_0100, 0, 0, -1, 1, 0, 0, 16'd1};
      vecs[1] = '{0, 32'h0000_0200, 1, 0,  3, 1, 0, 0, 16'd2};
      vecs[2] = '{0, 32'h0000_0300, 1, 1, -1, 1, 0, 0, 16'd3};
      vecs[3] = '{0, 32'h0000_0400, 1, 5, -1, 1, 0, 0, 16'd4};
      vecs[4] = '{1, 32'h0000_0500, 0, 0,  5, 0, 1, 0, 16'd0};
      vecs[5] = '{1, 32'h0000_0600, 1, 1, 17, 1, 0, 0, 16'd1};
      vecs[6] = '{1, 32'h0000_0700, 0, 0, -1, 1, 0, 1, 16'd2};
      vecs[7] = '{1, 32'h0000_0800, 1, 2, 17, 1, 0, 0, 16'd3};

      sel = 0;
      resetn = 1'b0;
      s_tdata = '0;
      s_tlast = 1'b0;
      frame_ack = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", r0, 1'b0);
      check("rst_valid", fv0, 1'b0);
      check("rst_start", fs0, 1'b0);
      check("rst_count", cnt0, 16'd0);
      check("rst_data", |fd0, 1'b0);
      check("rst_errs", {ee1, em1}, 2'b00);
      resetn = 1'b1;
      @(negedge clk);
      check("ready_after_rst", r0, 1'b1);
      check("ready_after_rst_t", r1, 1'b1);

      for (int t = 0; t < 8; t++) run_vec(vecs[t]);

      // mid-frame reset abandons the partial frame
      sel = 0;
      for (int i = 0; i < 9; i++) send_beat(32'h900 + 32'(i), 1'b0);
      set_valid(1'b0);
      resetn = 1'b0;
      #2;
      check("midrst_ready", r0, 1'b0);
      check("midrst_valid", fv0, 1'b0);
      check("midrst_count", cnt0, 16'd0);
      check("midrst_data", |fd0, 1'b0);
      check("midrst_count_t", cnt1, 16'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      rv = '{0, 32'h0000_0A00, 0, 0, -1, 1, 0, 0, 16'd1};
      run_vec(rv);

      // ack during FILL has no effect; counter wraps past 0xFFFF
      sel = 0;
      for (int i = 0; i < 4; i++) send_beat(32'hB00 + 32'(i), 1'b0);
      set_valid(1'b0);
      frame_ack = 1'b1;
      repeat (2) @(negedge clk);
      frame_ack = 1'b0;
      check("fill_ack_valid", fv0, 1'b0);
      check("fill_ack_ready", r0, 1'b1);
      check("fill_ack_start", fs0, 1'b0);
      force u0.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      release u0.frame_cnt_q;
      check("preset_count", cnt0, 16'hFFFF);
      for (int i = 4; i < N; i++) send_beat(32'hB00 + 32'(i), 1'b0);
      set_valid(1'b0);
      check("wrap_start", fs0, 1'b1);
      check("wrap_count", cnt0, 16'h0000);
      check_words(32'hB00, "wrap");
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      check("wrap_post_ack_valid", fv0, 1'b0);

      check("no_accept_in_hold", 32'(bad_acc), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
